// File: rtl/spi_mnrch_cfg_if.sv
// Bus bundle for the configurable SPI monarch: request/response handshake
// towards the control logic plus the four SPI pins towards the peripherals.
interface spi_mnrch_cfg_if #(
  parameter int DATA_W = 16,
  parameter int NUM_SS = 1
);
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              snd;
  logic [DATA_W-1:0] cmd;
  logic              cpol;
  logic              cpha;
  logic [SS_W-1:0]   ss_sel;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] resp;
  logic              MISO;
  logic              SCLK;
  logic              MOSI;
  logic [NUM_SS-1:0] SS_n;

  // Monarch side: consumes requests and MISO, drives the SPI pins and status.
  modport master (
    input  snd, cmd, cpol, cpha, ss_sel, MISO,
    output SCLK, MOSI, SS_n, busy, done, resp
  );

  // Requester / peripheral side.
  modport slave (
    output snd, cmd, cpol, cpha, ss_sel, MISO,
    input  SCLK, MOSI, SS_n, busy, done, resp
  );
endinterface

// File: rtl/spi_mnrch_cfg.sv
// Parametrised SPI monarch. One full-duplex frame of DATA_W bits per accepted
// snd, any of the four CPOL/CPHA modes, one of NUM_SS active-low selects.
// Frame timeline from T0 (cycle after accept): SCLK edge k at T0 + k*HALF,
// k = 1..2*DATA_W, then a HALF-cycle tail before selects are released.
module spi_mnrch_cfg #(
  parameter int DATA_W = 16,
  parameter int HALF   = 16,
  parameter int NUM_SS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_mnrch_cfg_if.master bus
);
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int HC_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int EC_W = $clog2(2 * DATA_W + 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF - 1);
  localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] sr_r, sr_s;
  logic              miso_q_r, miso_q_s;
  logic [HC_W-1:0]   hcnt_r, hcnt_s;
  logic [EC_W-1:0]   ecnt_r, ecnt_s;
  logic              cpol_l_r, cpol_l_s;
  logic              cpha_l_r, cpha_l_s;
  logic              sclk_r, sclk_s;
  logic [NUM_SS-1:0] ss_n_r, ss_n_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [DATA_W-1:0] resp_r, resp_s;

  logic              half_end_s;
  logic              is_lead_s;
  logic [DATA_W-1:0] shifted_s;

  // Active-low one-hot select; out-of-range indices leave every line high.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = {NUM_SS{1'b1}};
    for (int i = 0; i < NUM_SS; i++) begin
      v[i] = (sel == SS_W'(i)) ? 1'b0 : 1'b1;
    end
    return v;
  endfunction

  assign half_end_s = (hcnt_r == HC_LAST);
  // The edge about to happen is number ecnt_r+1: odd numbers are leading edges.
  assign is_lead_s  = (ecnt_r[0] == 1'b0);
  assign shifted_s  = {sr_r[DATA_W-2:0], miso_q_r};

  // Next-state and datapath update for the frame sequencer.
  always_comb begin
    state_s  = state_r;
    sr_s     = sr_r;
    miso_q_s = miso_q_r;
    hcnt_s   = hcnt_r;
    ecnt_s   = ecnt_r;
    cpol_l_s = cpol_l_r;
    cpha_l_s = cpha_l_r;
    sclk_s   = sclk_r;
    ss_n_s   = ss_n_r;
    busy_s   = busy_r;
    done_s   = done_r;
    resp_s   = resp_r;
    case (state_r)
      IDLE: begin
        sclk_s = bus.cpol;
        if (bus.snd) begin
          state_s  = XFER;
          sr_s     = bus.cmd;
          cpol_l_s = bus.cpol;
          cpha_l_s = bus.cpha;
          ss_n_s   = ss_decode(bus.ss_sel);
          busy_s   = 1'b1;
          done_s   = 1'b0;
          hcnt_s   = {HC_W{1'b0}};
          ecnt_s   = {EC_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        if (half_end_s) begin
          hcnt_s = {HC_W{1'b0}};
          sclk_s = ~sclk_r;
          ecnt_s = ecnt_r + 1'b1;
          if (is_lead_s != cpha_l_r) begin
            // sample edge
            miso_q_s = bus.MISO;
          end else if (cpha_l_r && (ecnt_r == {EC_W{1'b0}})) begin
            // cpha=1: first leading edge launches nothing, MSB is already out
            sr_s = sr_r;
          end else begin
            sr_s = shifted_s;
          end
          if (ecnt_r == EC_LAST) begin
            state_s = TAIL;
          end else begin
            state_s = XFER;
          end
        end else begin
          hcnt_s = hcnt_r + 1'b1;
        end
      end
      TAIL: begin
        if (half_end_s) begin
          state_s = IDLE;
          hcnt_s  = {HC_W{1'b0}};
          sclk_s  = cpol_l_r;
          ss_n_s  = {NUM_SS{1'b1}};
          busy_s  = 1'b0;
          done_s  = 1'b1;
          if (cpha_l_r) begin
            // commit the last sampled bit, which had no launch edge after it
            sr_s   = shifted_s;
            resp_s = shifted_s;
          end else begin
            resp_s = sr_r;
          end
        end else begin
          hcnt_s = hcnt_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sr_r     <= {DATA_W{1'b0}};
      miso_q_r <= 1'b0;
      hcnt_r   <= {HC_W{1'b0}};
      ecnt_r   <= {EC_W{1'b0}};
      cpol_l_r <= 1'b0;
      cpha_l_r <= 1'b0;
      sclk_r   <= 1'b0;
      ss_n_r   <= {NUM_SS{1'b1}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      resp_r   <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_s;
      sr_r     <= sr_s;
      miso_q_r <= miso_q_s;
      hcnt_r   <= hcnt_s;
      ecnt_r   <= ecnt_s;
      cpol_l_r <= cpol_l_s;
      cpha_l_r <= cpha_l_s;
      sclk_r   <= sclk_s;
      ss_n_r   <= ss_n_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      resp_r   <= resp_s;
    end
  end

  assign bus.SCLK = sclk_r;
  assign bus.MOSI = sr_r[DATA_W-1];
  assign bus.SS_n = ss_n_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.resp = resp_r;
endmodule
